team_select: RTL and testbench
==============================

Name: team_select

Overview:
- Upstream pre-battle stage: the player builds a 3-Pokemon team from an 8-entry roster with W/A/S/D/ENTER/BACKSPACE.
- Drives `team` and `is_battle` into the battle engine, holds the team stable for the whole battle, and consumes `end_battle`/`result`.
- Internal key-press edge detection, so a held key yields exactly one action.
- Exposes cursor, pick mask and win tally for the roster-screen renderer.

Parameters:
- NUM_MON, 8, roster size; ids 0..NUM_MON-1, max 8 (3-bit ids).
- GRID_COLS, 4, roster grid columns; rows = NUM_MON/GRID_COLS.

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- start  in  1  level; leaves IDLE into SELECT
- keycode  in  8  current USB keycode, 0 = no key
- end_battle  in  1  one-cycle pulse from battle engine
- result  in  1  sampled with end_battle; 1 = win
- team  out  [2:0][2:0]  slot0..slot2 Pokemon ids
- is_battle  out  1  battle request/hold
- cursor  out  3  hovered roster id
- picked_mask  out  8  bit i set = id i in team
- slot_count  out  2  number of filled slots, 0..3
- sel_state  out  3  IDLE=0, SELECT=1, CONFIRM=2, BATTLE=3, RESULT=4
- last_win  out  1  latched result of last battle
- win_count  out  8  battles won since reset, saturating

Behaviour:
- Reset values: state IDLE, team all 0, is_battle 0, cursor 0, picked_mask 0, slot_count 0, last_win 0, win_count 0, key history 0.
- Key event:
  - prev_key <= keycode every cycle.
  - press = (keycode != 0) && (keycode != prev_key).
  - All actions fire only on press, one cycle after the key appears (1-cycle latency).
- Keycodes: W=1A, A=04, S=16, D=07, ENTER=28, BACKSPACE=2A, R=15. Any other code is ignored.
- IDLE: start=1 -> SELECT. Clears team, picked_mask and slot_count on entry; cursor is unchanged.
- SELECT, cursor movement (no wrap; blocked moves leave cursor unchanged):
  - W: cursor -= GRID_COLS if cursor >= GRID_COLS.
  - S: cursor += GRID_COLS if cursor + GRID_COLS < NUM_MON.
  - A: cursor -= 1 if cursor % GRID_COLS != 0.
  - D: cursor += 1 if cursor % GRID_COLS != GRID_COLS-1.
- SELECT, ENTER:
  - If picked_mask[cursor] = 0: team[slot_count] <= cursor, set the mask bit, slot_count += 1.
  - Already picked: no effect.
  - When this fill makes slot_count 3, next state is CONFIRM.
- SELECT, BACKSPACE: if slot_count > 0, clear the mask bit of team[slot_count-1], set that slot to 0, slot_count -= 1. At 0: no effect.
- CONFIRM:
  - ENTER -> BATTLE; is_battle <= 1 on the same edge.
  - BACKSPACE -> SELECT with slot 2 removed as above.
  - Movement keys ignored.
- BATTLE:
  - is_battle held 1.
  - team, picked_mask and slot_count are frozen; all keys ignored.
  - On end_battle=1: is_battle <= 0, last_win <= result, win_count += result (saturates at FF), -> RESULT.
- RESULT:
  - ENTER -> SELECT with the team cleared.
  - BACKSPACE -> CONFIRM with the previous team kept, for a rematch.
  - Other keys ignored.
- Simultaneous events: end_battle outside BATTLE is ignored. start is ignored outside IDLE.
- Reset mid-operation returns everything to reset values on the next edge, including dropping is_battle.
- Invariant: team entries at index >= slot_count are 0. popcount(picked_mask) == slot_count.

Optional Feature:
- TEAM_AUTOFILL_EN defined:
  - R press in SELECT fills all remaining slots in one cycle with the lowest-index unpicked ids, in ascending order.
  - Sets slot_count=3 and goes to CONFIRM. At slot_count=3 there is no effect.
- Undefined: R is ignored like any unused keycode; no autofill logic is built.

Test Plan:
- Reset, start=1, hold D for 10 cycles -> cursor 0->1 exactly once; D held again without release -> no move; release then D x3 -> cursor 3, a further D -> stays 3.
- Pick sequence: ENTER at 0, S, ENTER (id 4), ENTER again at 4 -> team {0,4,0}, slot_count 2, mask 8'h11; D, ENTER (id 5) -> CONFIRM, team {0,4,5}, mask 8'h31.
- CONFIRM, BACKSPACE -> SELECT, slot_count 2, team[2]=0, mask 8'h11; BACKSPACE x3 -> slot_count 0, mask 0, no underflow.
- CONFIRM, ENTER -> is_battle 1 next cycle; keys and a stray start ignored; end_battle pulse with result=1 -> is_battle 0 after one edge, last_win 1, win_count 1, state RESULT.
- RESULT, BACKSPACE -> CONFIRM with team unchanged; force win_count=FF plus another win -> stays FF; Reset asserted during BATTLE -> is_battle 0, state IDLE.
- With TEAM_AUTOFILL_EN: pick id 2, press R -> team {2,0,1}, mask 8'h07, CONFIRM. Without the macro: R -> no change.

Source files
------------

// File: rtl/team_select.sv
`default_nettype none
// ============================================================================
//  Module      : team_select
//  Description : Pre-battle team builder. The player moves a cursor over an
//                NUM_MON-entry roster grid and picks a 3-Pokemon team with
//                W/A/S/D/ENTER/BACKSPACE. The stage then requests a battle,
//                holds the team stable while it runs, and records the result.
//                Key presses are edge-detected, so a held key acts only once.
//                Optional macro TEAM_AUTOFILL_EN: the R key fills the
//                remaining slots with the lowest unpicked ids.
//  Revision    : 1.0 - initial release
// ============================================================================
module team_select #(
    parameter int NUM_MON   = 8,
    parameter int GRID_COLS = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [7:0]           keycode,
    input  logic                 end_battle,
    input  logic                 result,
    output logic [2:0][2:0]      team,
    output logic                 is_battle,
    output logic [2:0]           cursor,
    output logic [NUM_MON-1:0]   picked_mask,
    output logic [1:0]           slot_count,
    output logic [2:0]           sel_state,
    output logic                 last_win,
    output logic [7:0]           win_count
);

    localparam logic [7:0] c_KEY_W     = 8'h1A;
    localparam logic [7:0] c_KEY_A     = 8'h04;
    localparam logic [7:0] c_KEY_S     = 8'h16;
    localparam logic [7:0] c_KEY_D     = 8'h07;
    localparam logic [7:0] c_KEY_ENTER = 8'h28;
    localparam logic [7:0] c_KEY_BKSP  = 8'h2A;
`ifdef TEAM_AUTOFILL_EN
    localparam logic [7:0] c_KEY_R     = 8'h15;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_CONFIRM = 3'd2,
        S_BATTLE  = 3'd3,
        S_RESULT  = 3'd4
    } state_t;

    state_t               r_state;
    logic [2:0][2:0]      r_team;
    logic                 r_is_battle;
    logic [2:0]           r_cursor;
    logic [NUM_MON-1:0]   r_mask;
    logic [1:0]           r_slot_count;
    logic                 r_last_win;
    logic [7:0]           r_win_count;
    logic [7:0]           r_prev_key;

    logic                 w_press;
    logic                 w_key_enter;
    logic                 w_key_bksp;
    logic [2:0]           w_cursor_mv;
    logic [1:0]           w_last_slot;
    int                   w_cur_int;

    // A press is a non-zero keycode that differs from last cycle's keycode.
    assign w_press     = (keycode != 8'h00) && (keycode != r_prev_key);
    assign w_key_enter = w_press && (keycode == c_KEY_ENTER);
    assign w_key_bksp  = w_press && (keycode == c_KEY_BKSP);
    assign w_last_slot = r_slot_count - 2'd1;
    assign w_cur_int   = int'(r_cursor);

    // Cursor target for a movement press; blocked moves at the grid edge hold.
    always_comb begin
        w_cursor_mv = r_cursor;
        if (w_press) begin
            if (keycode == c_KEY_W && w_cur_int >= GRID_COLS)
                w_cursor_mv = 3'(w_cur_int - GRID_COLS);
            else if (keycode == c_KEY_S && (w_cur_int + GRID_COLS) < NUM_MON)
                w_cursor_mv = 3'(w_cur_int + GRID_COLS);
            else if (keycode == c_KEY_A && (w_cur_int % GRID_COLS) != 0)
                w_cursor_mv = 3'(w_cur_int - 1);
            else if (keycode == c_KEY_D && (w_cur_int % GRID_COLS) != GRID_COLS - 1)
                w_cursor_mv = 3'(w_cur_int + 1);
        end
    end

`ifdef TEAM_AUTOFILL_EN
    logic                 w_key_r;
    logic [2:0][2:0]      w_af_team;
    logic [NUM_MON-1:0]   w_af_mask;

    assign w_key_r = w_press && (keycode == c_KEY_R);

    // Autofill: walk ids upward, dropping each unpicked id into the next free slot.
    always_comb begin
        int v_cnt;
        w_af_team = r_team;
        w_af_mask = r_mask;
        v_cnt     = int'(r_slot_count);
        for (int i = 0; i < NUM_MON; i++) begin
            if (!r_mask[i] && v_cnt < 3) begin
                w_af_team[v_cnt[1:0]] = 3'(i);
                w_af_mask[i]          = 1'b1;
                v_cnt                 = v_cnt + 1;
            end
        end
    end
`endif

    // Selection state machine with all outputs held in registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_team       <= '0;
            r_is_battle  <= 1'b0;
            r_cursor     <= 3'd0;
            r_mask       <= '0;
            r_slot_count <= 2'd0;
            r_last_win   <= 1'b0;
            r_win_count  <= 8'd0;
            r_prev_key   <= 8'd0;
        end else begin
            r_prev_key <= keycode;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_SELECT;
                        r_team       <= '0;
                        r_mask       <= '0;
                        r_slot_count <= 2'd0;
                    end
                end
                S_SELECT: begin
                    r_cursor <= w_cursor_mv;
                    if (w_key_enter) begin
                        if (!r_mask[r_cursor]) begin
                            r_team[r_slot_count] <= r_cursor;
                            r_mask[r_cursor]     <= 1'b1;
                            r_slot_count         <= r_slot_count + 2'd1;
                            if (r_slot_count == 2'd2)
                                r_state <= S_CONFIRM;
                        end
                    end else if (w_key_bksp) begin
                        if (r_slot_count != 2'd0) begin
                            r_mask[r_team[w_last_slot]] <= 1'b0;
                            r_team[w_last_slot]         <= 3'd0;
                            r_slot_count                <= w_last_slot;
                        end
                    end
`ifdef TEAM_AUTOFILL_EN
                    else if (w_key_r && r_slot_count != 2'd3) begin
                        r_team       <= w_af_team;
                        r_mask       <= w_af_mask;
                        r_slot_count <= 2'd3;
                        r_state      <= S_CONFIRM;
                    end
`endif
                end
                S_CONFIRM: begin
                    if (w_key_enter) begin
                        r_state     <= S_BATTLE;
                        r_is_battle <= 1'b1;
                    end else if (w_key_bksp) begin
                        r_mask[r_team[2]] <= 1'b0;
                        r_team[2]         <= 3'd0;
                        r_slot_count      <= 2'd2;
                        r_state           <= S_SELECT;
                    end
                end
                S_BATTLE: begin
                    if (end_battle) begin
                        r_is_battle <= 1'b0;
                        r_last_win  <= result;
                        if (result && r_win_count != 8'hFF)
                            r_win_count <= r_win_count + 8'd1;
                        r_state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (w_key_enter) begin
                        r_team       <= '0;
                        r_mask       <= '0;
                        r_slot_count <= 2'd0;
                        r_state      <= S_SELECT;
                    end else if (w_key_bksp) begin
                        r_state <= S_CONFIRM;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign team        = r_team;
    assign is_battle   = r_is_battle;
    assign cursor      = r_cursor;
    assign picked_mask = r_mask;
    assign slot_count  = r_slot_count;
    assign sel_state   = r_state;
    assign last_win    = r_last_win;
    assign win_count   = r_win_count;

endmodule
`default_nettype wire

// File: tb/tb_team_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_team_select
//  Description : Self-checking bench for team_select. A driver issues
//                directed and random key/battle stimulus and pushes the
//                expected outputs from a queue-based reference model; a
//                monitor pops and compares after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_team_select;

    localparam int NUM_MON   = 8;
    localparam int GRID_COLS = 4;

    localparam logic [7:0] c_KW = 8'h1A, c_KA = 8'h04, c_KS = 8'h16, c_KD = 8'h07;
    localparam logic [7:0] c_KENTER = 8'h28, c_KBS = 8'h2A, c_KR = 8'h15;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         keycode = 8'h00;
    logic               end_battle = 1'b0;
    logic               result = 1'b0;
    logic [2:0][2:0]    team;
    logic               is_battle;
    logic [2:0]         cursor;
    logic [7:0]         picked_mask;
    logic [1:0]         slot_count;
    logic [2:0]         sel_state;
    logic               last_win;
    logic [7:0]         win_count;

    team_select #(.NUM_MON(NUM_MON), .GRID_COLS(GRID_COLS)) u_dut (
        .Clk(Clk), .Reset(Reset), .start(start), .keycode(keycode),
        .end_battle(end_battle), .result(result), .team(team),
        .is_battle(is_battle), .cursor(cursor), .picked_mask(picked_mask),
        .slot_count(slot_count), .sel_state(sel_state), .last_win(last_win),
        .win_count(win_count)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model (spec-level) ----------------
    int m_state;      // 0 IDLE,1 SELECT,2 CONFIRM,3 BATTLE,4 RESULT
    int team_q[$];    // picked ids in slot order
    int m_cursor, m_wins;
    bit m_battle, m_last;
    logic [7:0] m_prev;

    logic [34:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    function automatic bit in_team(int id);
        foreach (team_q[i]) if (team_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [34:0] pack_exp();
        logic [2:0][2:0] t;
        logic [7:0]      m;
        t = '0;
        m = '0;
        foreach (team_q[i]) begin
            t[i] = 3'(team_q[i]);
            m[team_q[i]] = 1'b1;
        end
        return {t, m_battle, 3'(m_cursor), m, 2'(team_q.size()), 3'(m_state), m_last, 8'(m_wins)};
    endfunction

    task automatic model_step(input logic [7:0] k, input bit st, input bit eb, input bit res, input bit rst);
        bit press;
        int row, col;
        if (rst) begin
            m_state = 0; team_q.delete(); m_cursor = 0;
            m_battle = 0; m_last = 0; m_wins = 0; m_prev = 8'h00;
            return;
        end
        press  = (k != 8'h00) && (k != m_prev);
        m_prev = k;
        row = m_cursor / GRID_COLS;
        col = m_cursor % GRID_COLS;
        case (m_state)
            0: if (st) begin m_state = 1; team_q.delete(); end
            1: if (press) begin
                case (k)
                    c_KW: if (row > 0) m_cursor -= GRID_COLS;
                    c_KS: if (m_cursor + GRID_COLS < NUM_MON) m_cursor += GRID_COLS;
                    c_KA: if (col > 0) m_cursor -= 1;
                    c_KD: if (col < GRID_COLS - 1) m_cursor += 1;
                    c_KENTER: if (!in_team(m_cursor)) begin
                        team_q.push_back(m_cursor);
                        if (team_q.size() == 3) m_state = 2;
                    end
                    c_KBS: if (team_q.size() > 0) void'(team_q.pop_back());
`ifdef TEAM_AUTOFILL_EN
                    c_KR: if (team_q.size() < 3) begin
                        for (int id = 0; id < NUM_MON; id++)
                            if (!in_team(id) && team_q.size() < 3) team_q.push_back(id);
                        m_state = 2;
                    end
`endif
                    default: ;
                endcase
            end
            2: if (press && k == c_KENTER) begin m_state = 3; m_battle = 1; end
               else if (press && k == c_KBS) begin void'(team_q.pop_back()); m_state = 1; end
            3: if (eb) begin
                m_battle = 0; m_last = res;
                if (res && m_wins < 255) m_wins++;
                m_state = 4;
            end
            4: if (press && k == c_KENTER) begin team_q.delete(); m_state = 1; end
               else if (press && k == c_KBS) m_state = 2;
            default: ;
        endcase
    endtask

    // ---------------- driver helpers ----------------
    task automatic cycle(input logic [7:0] k, input bit st = 0, input bit eb = 0,
                         input bit res = 0, input bit rst = 0);
        @(negedge Clk);
        keycode = k; start = st; end_battle = eb; result = res; Reset = rst;
        model_step(k, st, eb, res, rst);
        exp_q.push_back(pack_exp());
    endtask

    task automatic tap(input logic [7:0] k);
        cycle(k);
        cycle(8'h00);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [34:0] act, exp_v;
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = {team, is_battle, cursor, picked_mask, slot_count, sel_state, last_win, win_count};
                n_checks++;
                if (act === exp_v) n_pass++;
                else $display("FAIL outputs cycle %0d: got team=%h bat=%b cur=%0d mask=%h cnt=%0d st=%0d lw=%b wins=%0d, expected team=%h bat=%b cur=%0d mask=%h cnt=%0d st=%0d lw=%b wins=%0d",
                              cyc, act[34:26], act[25], act[24:22], act[21:14], act[13:12], act[11:9], act[8], act[7:0],
                              exp_v[34:26], exp_v[25], exp_v[24:22], exp_v[21:14], exp_v[13:12], exp_v[11:9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    // Run-time bound in case the driver stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] keys [9];
        logic [7:0] k;
        keys = '{8'h00, c_KW, c_KA, c_KS, c_KD, c_KENTER, c_KBS, c_KR, 8'h33};

        cycle(8'h00, 0, 0, 0, 1);
        cycle(8'h00, 0, 0, 0, 1);
        cycle(8'h00);                                // reset values hold
        cycle(8'h00, 1);                             // IDLE -> SELECT
        repeat (10) cycle(c_KD);                     // held D moves once
        repeat (3) cycle(c_KD, 1);                   // still held, stray start
        cycle(8'h00);
        repeat (4) tap(c_KD);                        // 2,3 then blocked
        repeat (3) tap(c_KA);                        // back to 0
        tap(c_KENTER); tap(c_KS); tap(c_KENTER); tap(c_KENTER);
        tap(c_KD); tap(c_KENTER);                    // team {0,4,5} -> CONFIRM
        tap(c_KBS);                                  // back to SELECT
        repeat (3) tap(c_KBS);                       // no underflow
        tap(c_KW); tap(c_KENTER); tap(c_KD); tap(c_KENTER); tap(c_KS); tap(c_KENTER);
        tap(c_KW);                                   // ignored in CONFIRM
        tap(c_KENTER);                               // -> BATTLE
        tap(c_KA); tap(c_KBS); cycle(8'h00, 1);      // ignored in BATTLE
        cycle(8'h00, 0, 1, 1);                       // win
        cycle(8'h00, 0, 1, 0);                       // end_battle outside BATTLE
        tap(c_KBS);                                  // rematch -> CONFIRM
        for (int i = 0; i < 258; i++) begin          // saturate win counter
            tap(c_KENTER);
            cycle(8'h00, 0, 1, 1);
            tap(c_KBS);
        end
        tap(c_KENTER);
        cycle(8'h00);
        cycle(8'h00, 0, 0, 0, 1);                    // reset during BATTLE
        cycle(8'h00);
        cycle(8'h00, 1);
        tap(c_KD); tap(c_KD); tap(c_KENTER);         // pick id 2
        tap(c_KR);                                   // autofill or ignored
        tap(c_KBS);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0) k = keycode;
            else k = keys[$urandom_range(0, 8)];
            cycle(k, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
        end

        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
